// File: rtl/program_loader.sv
// Host-side program loader: streams bytes into the CPU program RAM, verifies a
// trailing two's-complement checksum, and releases the CPU only after a clean load.
module program_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4:0]        load_len,
    input  logic              abort,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              busy,
    output logic              cpu_run,
    output logic              load_err,
    output logic [4:0]        bytes_loaded
);

    localparam int LEN_W = 5;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] sum;

    logic              xfer;
    logic              start_ok;
    logic              len_ok;
    logic [DATA_W-1:0] sum_next;
    logic [LEN_W-1:0]  count_next;

    assign xfer       = in_valid && in_ready;
    assign start_ok   = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
    assign len_ok     = (load_len != '0) && (load_len <= MAX_LEN);
    assign sum_next   = sum + in_data;
    assign count_next = bytes_loaded + LEN_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_ok) state_next = len_ok ? S_LOAD : S_ERROR;
            end
            S_LOAD: begin
                if (abort)                           state_next = S_ERROR;
                else if (xfer && count_next == len)  state_next = S_CHECK;
            end
            S_CHECK: begin
                if (abort)     state_next = S_ERROR;
                else if (xfer) state_next = (sum_next == '0) ? S_DONE : S_ERROR;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // abort masks in_ready combinationally so an aborted cycle can never transfer.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        if (state == S_LOAD || state == S_CHECK) begin
            busy     = 1'b1;
            in_ready = !abort;
        end
    end

    // cpu_run and load_err are registered from state_next so they track DONE/ERROR
    // exactly, glitch-free, and cpu_run can never overlap busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_run  <= 1'b0;
            load_err <= 1'b0;
        end else begin
            cpu_run  <= (state_next == S_DONE);
            load_err <= (state_next == S_ERROR);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len          <= '0;
            sum          <= '0;
            bytes_loaded <= '0;
            ram_wr_en    <= 1'b0;
            ram_addr     <= '0;
            ram_data     <= '0;
        end else begin
            ram_wr_en <= 1'b0;
            if (start_ok) begin
                len          <= load_len;
                sum          <= '0;
                bytes_loaded <= '0;
            end else if (state == S_LOAD && xfer) begin
                // len never exceeds DEPTH, so the address stays in range without wrapping.
                ram_wr_en    <= 1'b1;
                ram_addr     <= bytes_loaded[ADDR_W-1:0];
                ram_data     <= in_data;
                bytes_loaded <= count_next;
                sum          <= sum_next;
            end
        end
    end

endmodule
